// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue producing predictor updates.
// Optional BRQ_MISPRED_CNT_EN adds a saturating mispredict counter output.
`ifndef XLEN
`define XLEN 32
`endif

module branch_resolve_queue #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         dispatch_EN,
  input  logic [3*`XLEN-1:0] dispatch_pc,
  input  logic [2:0]         dispatch_pred_dir,
  input  logic [3*`XLEN-1:0] dispatch_pred_pc,
  output logic [3*IDX_W-1:0] dispatch_idx,
  output logic [IDX_W:0]     free_cnt,
  input  logic               resolve_EN,
  input  logic [IDX_W-1:0]   resolve_idx,
  input  logic               resolve_direction,
  input  logic [`XLEN-1:0]   resolve_target,
  input  logic               squash,
  output logic               update_EN,
  output logic [`XLEN-1:0]   update_pc,
  output logic               update_direction,
  output logic [`XLEN-1:0]   update_target,
  output logic               mispredict,
  output logic [`XLEN-1:0]   mispredict_pc
`ifdef BRQ_MISPRED_CNT_EN
  ,
  output logic [31:0]        mispred_count
`endif
);
  localparam int XL = `XLEN;
  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_W = (IDX_W+1)'(1);

  logic [IDX_W:0]   r_head;
  logic [IDX_W:0]   r_tail;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_res;
  logic [DEPTH-1:0] r_pdir;
  logic [DEPTH-1:0] r_adir;
  logic [XL-1:0]    r_pc   [DEPTH];
  logic [XL-1:0]    r_ppc  [DEPTH];
  logic [XL-1:0]    r_atgt [DEPTH];

  logic [IDX_W-1:0] w_hidx;
  logic [IDX_W-1:0] w_tidx;
  logic [IDX_W-1:0] w_sidx [3];
  logic [1:0]       w_ncnt;
  logic             w_alloc;
  logic             w_hready;
  logic             w_mis;
  logic             w_flush;
  logic             w_res_ok;

  assign w_hidx   = r_head[IDX_W-1:0];
  assign w_tidx   = r_tail[IDX_W-1:0];
  assign free_cnt = DEPTH_W - (r_tail - r_head);

  // Slot 2 is oldest and takes the tail; younger enabled slots follow.
  assign w_ncnt = {1'b0, dispatch_EN[0]} + {1'b0, dispatch_EN[1]}
                + {1'b0, dispatch_EN[2]};
  assign w_sidx[2] = w_tidx;
  assign w_sidx[1] = w_tidx + IDX_W'(dispatch_EN[2]);
  assign w_sidx[0] = w_tidx + IDX_W'(dispatch_EN[2])
                   + IDX_W'(dispatch_EN[1]);
  assign dispatch_idx = {w_sidx[2], w_sidx[1], w_sidx[0]};

  assign w_alloc = (w_ncnt != 2'd0)
                && ((IDX_W+1)'(w_ncnt) <= free_cnt);

  assign w_res_ok = resolve_EN && r_valid[resolve_idx]
                 && !r_res[resolve_idx];

  assign w_hready  = r_valid[w_hidx] && r_res[w_hidx];
  assign update_EN = w_hready && !squash;

  assign update_pc        = update_EN ? r_pc[w_hidx] : '0;
  assign update_direction = update_EN ? r_adir[w_hidx] : 1'b0;
  assign update_target    = update_EN ? r_atgt[w_hidx] : '0;

  assign w_mis = update_EN
              && ((r_pdir[w_hidx] != r_adir[w_hidx])
               || (r_adir[w_hidx]
                && (r_ppc[w_hidx] != r_atgt[w_hidx])));

  assign mispredict    = w_mis;
  assign mispredict_pc = !w_mis ? '0 :
                         r_adir[w_hidx] ? r_atgt[w_hidx] :
                         r_pc[w_hidx] + XL'(4);

  assign w_flush = squash || w_mis;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_res   <= '0;
    end else if (w_flush) begin
      r_head  <= r_tail;
      r_valid <= '0;
      r_res   <= '0;
    end else begin
      if (update_EN) begin
        r_valid[w_hidx] <= 1'b0;
        r_res[w_hidx]   <= 1'b0;
        r_head          <= r_head + ONE_W;
      end
      if (w_res_ok) r_res[resolve_idx] <= 1'b1;
      if (w_alloc) begin
        for (int s = 0; s < 3; s++) begin
          if (dispatch_EN[s]) begin
            r_valid[w_sidx[s]] <= 1'b1;
            r_res[w_sidx[s]]   <= 1'b0;
          end
        end
        r_tail <= r_tail + (IDX_W+1)'(w_ncnt);
      end
    end
  end

  // Payload is qualified by r_valid/r_res, so it needs no reset.
  always_ff @(posedge clock) begin
    if (w_res_ok) begin
      r_adir[resolve_idx] <= resolve_direction;
      r_atgt[resolve_idx] <= resolve_target;
    end
    for (int s = 0; s < 3; s++) begin
      if (w_alloc && dispatch_EN[s]) begin
        r_pc[w_sidx[s]]   <= dispatch_pc[s*XL +: XL];
        r_pdir[w_sidx[s]] <= dispatch_pred_dir[s];
        r_ppc[w_sidx[s]]  <= dispatch_pred_pc[s*XL +: XL];
        r_adir[w_sidx[s]] <= 1'b0;
        r_atgt[w_sidx[s]] <= '0;
      end
    end
  end

`ifdef BRQ_MISPRED_CNT_EN
  logic [31:0] r_mcnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcnt <= '0;
    end else if (w_mis && (r_mcnt != '1)) begin
      r_mcnt <= r_mcnt + 32'd1;
    end
  end

  assign mispred_count = r_mcnt;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue.
// Vector table plus a transaction-level scoreboard checked every cycle.
module tb_branch_resolve_queue;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int XL = 32;

  logic               clock = 1'b0;
  logic               reset;
  logic [2:0]         dispatch_EN;
  logic [3*XL-1:0]    dispatch_pc;
  logic [2:0]         dispatch_pred_dir;
  logic [3*XL-1:0]    dispatch_pred_pc;
  logic [3*IDX_W-1:0] dispatch_idx;
  logic [IDX_W:0]     free_cnt;
  logic               resolve_EN;
  logic [IDX_W-1:0]   resolve_idx;
  logic               resolve_direction;
  logic [XL-1:0]      resolve_target;
  logic               squash;
  logic               update_EN;
  logic [XL-1:0]      update_pc;
  logic               update_direction;
  logic [XL-1:0]      update_target;
  logic               mispredict;
  logic [XL-1:0]      mispredict_pc;
`ifdef BRQ_MISPRED_CNT_EN
  logic [31:0]        mispred_count;
`endif

  always #5 clock = ~clock;

  branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset(reset),
    .dispatch_EN(dispatch_EN), .dispatch_pc(dispatch_pc),
    .dispatch_pred_dir(dispatch_pred_dir),
    .dispatch_pred_pc(dispatch_pred_pc),
    .dispatch_idx(dispatch_idx), .free_cnt(free_cnt),
    .resolve_EN(resolve_EN), .resolve_idx(resolve_idx),
    .resolve_direction(resolve_direction),
    .resolve_target(resolve_target), .squash(squash),
    .update_EN(update_EN), .update_pc(update_pc),
    .update_direction(update_direction),
    .update_target(update_target), .mispredict(mispredict),
    .mispredict_pc(mispredict_pc)
`ifdef BRQ_MISPRED_CNT_EN
    , .mispred_count(mispred_count)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  bit          m_val [DEPTH];
  bit          m_res [DEPTH];
  bit          m_pd  [DEPTH];
  bit          m_ad  [DEPTH];
  logic [31:0] m_pc  [DEPTH];
  logic [31:0] m_ppc [DEPTH];
  logic [31:0] m_at  [DEPTH];
  int          q[$];
  int          m_tail = 0;
  int          m_cnt = 0;
  int          m_mis = 0;
  int          n_dut_upd = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pd;
    logic [31:0] ppc;
    logic        ad;
    logic [31:0] at;
    logic        emis;
    logic [31:0] empc;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic idle();
    reset = 1'b0;
    dispatch_EN = '0;
    dispatch_pc = '0;
    dispatch_pred_dir = '0;
    dispatch_pred_pc = '0;
    resolve_EN = 1'b0;
    resolve_idx = '0;
    resolve_direction = 1'b0;
    resolve_target = '0;
    squash = 1'b0;
  endtask

  task automatic clr();
    q.delete();
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_val[i] = 0;
      m_res[i] = 0;
    end
  endtask

  task automatic set_slot(input int s, input logic [31:0] pc,
                          input logic pd, input logic [31:0] ppc);
    dispatch_pc[s*XL +: XL] = pc;
    dispatch_pred_dir[s] = pd;
    dispatch_pred_pc[s*XL +: XL] = ppc;
  endtask

  task automatic res(input int idx, input logic d, input logic [31:0] t);
    resolve_EN = 1'b1;
    resolve_idx = IDX_W'(idx);
    resolve_direction = d;
    resolve_target = t;
  endtask

  // Scoreboard step: compare outputs to the model, then advance it.
  task automatic mon();
    int cnt0, n, h, k, e;
    bit eu, em;
    logic [31:0] empc;
    if (reset) begin
      clr();
      m_tail = 0;
      m_mis = 0;
      return;
    end
`ifdef BRQ_MISPRED_CNT_EN
    chk("sb_mis_count", mispred_count, m_mis);
`endif
    if (update_EN === 1'b1) n_dut_upd++;
    cnt0 = m_cnt;
    chk("sb_free_cnt", free_cnt, DEPTH - m_cnt);
    eu = (q.size() > 0) && m_res[q[0]] && !squash;
    chk("sb_update_EN", update_EN, eu);
    em = 0;
    empc = 0;
    h = 0;
    if (eu) begin
      h = q[0];
      em = (m_pd[h] != m_ad[h]) || (m_ad[h] && (m_ppc[h] != m_at[h]));
      if (em) empc = m_ad[h] ? m_at[h] : m_pc[h] + 32'd4;
      chk("sb_update_pc", update_pc, m_pc[h]);
      chk("sb_update_dir", update_direction, m_ad[h]);
      chk("sb_update_tgt", update_target, m_at[h]);
    end else begin
      chk("sb_update_pc_idle", update_pc, 0);
    end
    chk("sb_mispredict", mispredict, em);
    chk("sb_mispredict_pc", mispredict_pc, empc);
    if (squash || em) begin
      if (em) m_mis++;
      clr();
      return;
    end
    if (eu) begin
      m_val[h] = 0;
      m_res[h] = 0;
      void'(q.pop_front());
      m_cnt--;
    end
    if (resolve_EN && m_val[resolve_idx] && !m_res[resolve_idx]) begin
      m_res[resolve_idx] = 1;
      m_ad[resolve_idx] = resolve_direction;
      m_at[resolve_idx] = resolve_target;
    end
    n = $countones(dispatch_EN);
    if (n > 0 && n <= DEPTH - cnt0) begin
      k = 0;
      for (int s = 2; s >= 0; s--) begin
        if (dispatch_EN[s]) begin
          e = (m_tail + k) % DEPTH;
          chk("sb_dispatch_idx", dispatch_idx[s*IDX_W +: IDX_W], e);
          m_val[e] = 1;
          m_res[e] = 0;
          m_pc[e] = dispatch_pc[s*XL +: XL];
          m_pd[e] = dispatch_pred_dir[s];
          m_ppc[e] = dispatch_pred_pc[s*XL +: XL];
          m_ad[e] = 0;
          m_at[e] = 0;
          q.push_back(e);
          k++;
        end
      end
      m_tail = (m_tail + n) % DEPTH;
      m_cnt += n;
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    mon();
    @(posedge clock);
    #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int e, p, start0;
    int lst[$];
    tv[0] = '{32'h500, 1'b1, 32'h300, 1'b1, 32'h340, 1'b1, 32'h340};
    tv[1] = '{32'h600, 1'b0, 32'h000, 1'b1, 32'h400, 1'b1, 32'h400};
    tv[2] = '{32'h700, 1'b1, 32'h800, 1'b0, 32'h000, 1'b1, 32'h704};
    tv[3] = '{32'h900, 1'b1, 32'hA00, 1'b1, 32'hA00, 1'b0, 32'h000};
    tv[4] = '{32'hB00, 1'b0, 32'h123, 1'b0, 32'h055, 1'b0, 32'h000};

    idle();
    clr();
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    idle();
    chk("rst_free", free_cnt, 16);
    chk("rst_upd_en", update_EN, 0);
    chk("rst_mis", mispredict, 0);
    chk("rst_upd_pc", update_pc, 0);
    chk("rst_mis_pc", mispredict_pc, 0);
`ifdef BRQ_MISPRED_CNT_EN
    chk("rst_mis_count", mispred_count, 0);
`endif

    set_slot(2, 32'h100, 1'b0, 32'h0);
    set_slot(1, 32'h104, 1'b1, 32'h200);
    set_slot(0, 32'h108, 1'b0, 32'h0);
    dispatch_EN = 3'b111;
    #1;
    chk("a_idx2", dispatch_idx[8 +: 4], 0);
    chk("a_idx1", dispatch_idx[4 +: 4], 1);
    chk("a_idx0", dispatch_idx[0 +: 4], 2);
    cyc();
    chk("a_free13", free_cnt, 13);
    res(1, 1'b1, 32'h200);
    cyc();
    chk("a_wait_head", update_EN, 0);
    res(0, 1'b0, 32'h0);
    cyc();
    chk("a_upd0_en", update_EN, 1);
    chk("a_upd0_pc", update_pc, 32'h100);
    cyc();
    chk("a_upd1_pc", update_pc, 32'h104);
    chk("a_upd1_mis", mispredict, 0);
    cyc();
    chk("a_blocked", update_EN, 0);
    res(2, 1'b0, 32'h0);
    cyc();
    chk("a_upd2_pc", update_pc, 32'h108);
    cyc();
    chk("a_free16", free_cnt, 16);

    for (int i = 0; i < 5; i++) begin
      e = m_tail;
      set_slot(2, tv[i].pc, tv[i].pd, tv[i].ppc);
      dispatch_EN = 3'b100;
      cyc();
      res(e, tv[i].ad, tv[i].at);
      cyc();
      chk("tv_upd_en", update_EN, 1);
      chk("tv_mis", mispredict, tv[i].emis);
      chk("tv_mis_pc", mispredict_pc, tv[i].empc);
      chk("tv_tgt", update_target, tv[i].at);
      cyc();
      chk("tv_free", free_cnt, 16);
      chk("tv_upd_en_after", update_EN, 0);
    end

    e = m_tail;
    set_slot(2, 32'h3000, 1'b0, 32'h0);
    dispatch_EN = 3'b100;
    cyc();
    res(e, 1'b0, 32'h0);
    cyc();
    squash = 1'b1;
    set_slot(1, 32'h3004, 1'b0, 32'h0);
    set_slot(0, 32'h3008, 1'b0, 32'h0);
    dispatch_EN = 3'b011;
    #1;
    chk("sq_upd_en", update_EN, 0);
    chk("sq_mis", mispredict, 0);
    cyc();
    chk("sq_free", free_cnt, 16);
    chk("sq_upd_after", update_EN, 0);
`ifdef BRQ_MISPRED_CNT_EN
    chk("cnt_three", mispred_count, 3);
`endif

    p = 32'h1000;
    for (int g = 0; g < 5; g++) begin
      for (int s = 0; s < 3; s++) begin
        set_slot(s, p, 1'b0, 32'h0);
        p += 4;
      end
      dispatch_EN = (g == 4) ? 3'b011 : 3'b111;
      cyc();
    end
    chk("fill_free2", free_cnt, 2);
    for (int s = 0; s < 3; s++) set_slot(s, 32'hDEAD0000, 1'b0, 32'h0);
    dispatch_EN = 3'b111;
    cyc();
    chk("reject_free2", free_cnt, 2);
    set_slot(0, p, 1'b0, 32'h0);
    dispatch_EN = 3'b001;
    cyc();
    chk("fill_free1", free_cnt, 1);

    lst = q;
    for (int k = lst.size() - 1; k >= 0; k--) begin
      res(lst[k], 1'b0, 32'h0);
      cyc();
    end
    start0 = n_dut_upd;
    set_slot(2, 32'h2000, 1'b0, 32'h0);
    dispatch_EN = 3'b100;
    cyc();
    chk("drain_alloc_free", free_cnt, 1);
    for (int c = 0; c < 40 && (n_dut_upd - start0) < 15; c++) cyc();
    chk("drain_count", n_dut_upd - start0, 15);
    chk("drain_free", free_cnt, 15);

    reset = 1'b1;
    cyc();
    chk("mid_rst_free", free_cnt, 16);
    chk("mid_rst_upd", update_EN, 0);
`ifdef BRQ_MISPRED_CNT_EN
    chk("mid_rst_count", mispred_count, 0);
`endif
    set_slot(2, 32'h4000, 1'b0, 32'h0);
    set_slot(1, 32'h4004, 1'b0, 32'h0);
    set_slot(0, 32'h4008, 1'b0, 32'h0);
    dispatch_EN = 3'b111;
    #1;
    chk("post_idx2", dispatch_idx[8 +: 4], 0);
    chk("post_idx0", dispatch_idx[0 +: 4], 2);
    cyc();
    chk("post_free13", free_cnt, 13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

- Producer side of the branch predictor's update interface.
- Holds one entry per dispatched branch: PC, predicted direction and predicted target.
- Collects out-of-order resolutions from the branch FU.
- Drains resolved entries in program order, one per cycle, as a predictor update (update_EN/update_pc/update_direction/update_target) and flags mispredictions with the corrected fetch PC.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥4
- IDX_W, $clog2(DEPTH), entry index width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dispatch_EN  in  3  per-slot branch allocate enable; slot 2 is oldest
- dispatch_pc  in  3×`XLEN  branch PC per slot
- dispatch_pred_dir  in  3  predicted direction per slot (1 = taken)
- dispatch_pred_pc  in  3×`XLEN  predicted target per slot
- dispatch_idx  out  3×IDX_W  queue index assigned to each slot this cycle (combinational)
- free_cnt  out  IDX_W+1  number of free entries (registered state)
- resolve_EN  in  1  branch FU result valid
- resolve_idx  in  IDX_W  entry being resolved
- resolve_direction  in  1  actual direction
- resolve_target  in  `XLEN  actual taken target
- squash  in  1  external flush of all entries
- update_EN  out  1  head entry drains this cycle
- update_pc  out  `XLEN  head PC
- update_direction  out  1  head actual direction
- update_target  out  `XLEN  head actual target
- mispredict  out  1  drained head was mispredicted
- mispredict_pc  out  `XLEN  corrected fetch PC

## Operation
- Storage and pointers
  - Circular buffer of DEPTH entries; each entry holds {valid, resolved, pc, pred_dir, pred_pc, act_dir, act_target}.
  - head and tail pointers are IDX_W+1 bits; the MSB is the wrap bit.
  - Empty: head == tail. Full: low bits equal and MSBs differ.
  - free_cnt = DEPTH − (tail − head).
- Allocation
  - Enabled slots allocate in order 2, 1, 0 at consecutive tail indices; disabled slots are skipped.
  - dispatch_idx for an enabled slot = tail + (number of enabled older slots), mod DEPTH. For disabled slots it is don't-care.
  - If popcount(dispatch_EN) > free_cnt, nothing is allocated (atomic group reject) and tail holds.
- Resolution
  - resolve_EN on a valid, unresolved entry sets resolved and writes act_dir/act_target.
  - Resolution of an invalid or already-resolved entry is ignored.
- Drain
  - update_EN = head valid && head resolved && !squash.
  - update_* carry the head fields and are forced to 0 when update_EN = 0.
  - The head pops on the clock edge ending an update_EN cycle.
- Misprediction
  - mispredict = update_EN && (pred_dir != act_dir || (act_dir && pred_pc != act_target)).
  - mispredict_pc = act_dir ? act_target : pc + 4; it is 0 when mispredict = 0.
  - On a mispredict edge the whole queue empties: head = tail, all valid bits cleared. Dispatch and resolve inputs in that cycle are discarded.
- squash
  - On the edge, the queue empties.
  - squash has priority over dispatch, resolve and drain.

## Timing
- Reset values: head = tail = 0, all valid = 0, free_cnt = DEPTH, update_EN = 0, mispredict = 0. All other outputs are 0.
- Dispatch in cycle t: entry visible (valid) from t+1. free_cnt drops at t+1.
- Resolve in cycle t of the head entry: update_EN = 1 in t+1. Minimum resolve-to-update latency is 1 cycle.
- At most one drain per cycle. Younger resolved entries wait behind an unresolved head.
- Same-cycle drain and dispatch are both applied: free_cnt(t+1) = free_cnt(t) + 1 − allocated.
  - The reject check uses registered free_cnt and does not count the same-cycle pop.
- A resolve to an index being allocated in the same cycle is ignored.
- Pointer wrap is by natural IDX_W+1-bit overflow.
- Reset asserted mid-operation discards all entries at that edge, identical to the post-reset state.

## Configuration
- Macro: BRQ_MISPRED_CNT_EN.
- Defined:
  - Adds output mispred_count (32 bits), a saturating count of mispredict cycles.
  - Cleared only by reset; unaffected by squash.
  - Increments at the edge ending each mispredict cycle.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then dispatch_EN=3'b111 with pc 0x100/0x104/0x108 → dispatch_idx 0/1/2; free_cnt=13 next cycle (DEPTH=16).
- Resolve idx 1 (taken, 0x200), then idx 0 (not taken, pred NT) → update for pc 0x100 one cycle after idx 0 resolves, pc 0x104 the following cycle; update_EN=0 while idx 2 is unresolved.
- Head predicted taken to 0x300, resolves taken to 0x340 → mispredict=1, mispredict_pc=0x340; next cycle free_cnt=16, update_EN=0. Same check with pred NT, resolved taken, target 0x400 → mispredict_pc=0x400.
- Fill to 14 entries, dispatch 3 → whole group rejected, free_cnt stays 2. Then drain 15 entries across wrap and verify head/tail wrap with correct ordering.
- squash in the same cycle as dispatch_EN=3'b011 and a ready head → update_EN=0; queue empty next cycle.
- With BRQ_MISPRED_CNT_EN: 3 mispredicts, then squash → mispred_count=3; reset → 0.
